uart_tx_fifo: RTL

UART transmit path for the peripheral subsystem: 8N1/8N2 serializer with a small byte FIFO in front. The bus-side register block pushes bytes with a valid/ready handshake and supplies the bit-period divisor. The block drives the serial line and pulses an interrupt per completed frame. It pairs with the existing receive path on the same divisor, so one clock-per-bit value serves both directions.

---
 rtl/uart_tx_fifo.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmit path: in-order byte FIFO feeding an 8N1/8N2 serializer.
// The bit period is latched at each frame start; intr_tx_o pulses once per finished frame.
module uart_tx_fifo #(
  parameter int DEPTH     = 4,
  parameter int STOP_BITS = 1,
  parameter int DIV_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [DIV_W-1:0] baud_div_i,
  input  logic             tx_en_i,
  input  logic [7:0]       data_i,
  input  logic             data_valid_i,
  output logic             data_ready_o,
  output logic             tx_o,
  output logic             busy_o,
  output logic             tx_empty_o,
  output logic             intr_tx_o
);
  localparam int          AW          = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C     = (AW+1)'(DEPTH);
  localparam logic [AW:0] ZERO_C      = (AW+1)'(0);
  localparam logic        LAST_STOP_C = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  logic [7:0]       mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;

  state_e           state_r;
  state_e           state_n_s;
  logic [7:0]       shift_r;
  logic [7:0]       shift_n_s;
  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] div_n_s;
  logic [DIV_W-1:0] baud_cnt_r;
  logic [DIV_W-1:0] baud_cnt_n_s;
  logic [2:0]       bit_idx_r;
  logic [2:0]       bit_idx_n_s;
  logic             stop_cnt_r;
  logic             stop_cnt_n_s;
  logic             tx_r;
  logic             tx_n_s;
  logic             busy_r;
  logic             intr_r;
  logic             intr_n_s;

  logic             push_s;
  logic             pop_s;
  logic             start_ok_s;
  logic [DIV_W-1:0] div_eff_s;
  logic [7:0]       head_s;

  assign data_ready_o = (count_r < DEPTH_C);
  assign tx_empty_o   = (count_r == ZERO_C) && (state_r == IDLE);
  assign push_s       = data_valid_i && data_ready_o;
  assign start_ok_s   = (count_r != ZERO_C) && tx_en_i;
  // Divisors below 2 are forced to 2 so the down-counter never wraps.
  assign div_eff_s    = (baud_div_i < DIV_W'(2)) ? DIV_W'(2) : baud_div_i;
  assign head_s       = mem_r[rd_ptr_r];

  assign tx_o      = tx_r;
  assign busy_o    = busy_r;
  assign intr_tx_o = intr_r;

  // FIFO storage write port
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= data_i;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at a power-of-two depth
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= ZERO_C;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Serializer state and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= IDLE;
      shift_r    <= 8'h00;
      div_r      <= DIV_W'(0);
      baud_cnt_r <= DIV_W'(0);
      bit_idx_r  <= 3'd0;
      stop_cnt_r <= 1'b0;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      intr_r     <= 1'b0;
    end else begin
      state_r    <= state_n_s;
      shift_r    <= shift_n_s;
      div_r      <= div_n_s;
      baud_cnt_r <= baud_cnt_n_s;
      bit_idx_r  <= bit_idx_n_s;
      stop_cnt_r <= stop_cnt_n_s;
      tx_r       <= tx_n_s;
      busy_r     <= (state_n_s != IDLE);
      intr_r     <= intr_n_s;
    end
  end

  // Next-state and datapath logic for the frame sequencer
  always_comb begin
    state_n_s    = state_r;
    shift_n_s    = shift_r;
    div_n_s      = div_r;
    baud_cnt_n_s = baud_cnt_r;
    bit_idx_n_s  = bit_idx_r;
    stop_cnt_n_s = stop_cnt_r;
    tx_n_s       = tx_r;
    intr_n_s     = 1'b0;
    pop_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_ok_s) begin
          pop_s        = 1'b1;
          shift_n_s    = head_s;
          div_n_s      = div_eff_s;
          baud_cnt_n_s = div_eff_s - DIV_W'(1);
          tx_n_s       = 1'b0;
          state_n_s    = START;
        end else begin
          tx_n_s = 1'b1;
        end
      end
      START: begin
        if (baud_cnt_r == DIV_W'(0)) begin
          state_n_s    = DATA;
          bit_idx_n_s  = 3'd0;
          tx_n_s       = shift_r[0];
          baud_cnt_n_s = div_r - DIV_W'(1);
        end else begin
          baud_cnt_n_s = baud_cnt_r - DIV_W'(1);
        end
      end
      DATA: begin
        if (baud_cnt_r != DIV_W'(0)) begin
          baud_cnt_n_s = baud_cnt_r - DIV_W'(1);
        end else if (bit_idx_r == 3'd7) begin
          state_n_s    = STOP;
          stop_cnt_n_s = 1'b0;
          tx_n_s       = 1'b1;
          baud_cnt_n_s = div_r - DIV_W'(1);
        end else begin
          bit_idx_n_s  = bit_idx_r + 3'd1;
          shift_n_s    = {1'b0, shift_r[7:1]};
          tx_n_s       = shift_r[1];
          baud_cnt_n_s = div_r - DIV_W'(1);
        end
      end
      STOP: begin
        if (baud_cnt_r != DIV_W'(0)) begin
          baud_cnt_n_s = baud_cnt_r - DIV_W'(1);
        end else if (stop_cnt_r != LAST_STOP_C) begin
          stop_cnt_n_s = stop_cnt_r + 1'b1;
          baud_cnt_n_s = div_r - DIV_W'(1);
        end else begin
          // Frame done: chain straight into the next start bit when possible.
          intr_n_s = 1'b1;
          if (start_ok_s) begin
            pop_s        = 1'b1;
            shift_n_s    = head_s;
            div_n_s      = div_eff_s;
            baud_cnt_n_s = div_eff_s - DIV_W'(1);
            tx_n_s       = 1'b0;
            state_n_s    = START;
          end else begin
            tx_n_s    = 1'b1;
            state_n_s = IDLE;
          end
        end
      end
      default: begin
        state_n_s = IDLE;
        tx_n_s    = 1'b1;
      end
    endcase
  end

endmodule
